turn_scheduler: RTL and testbench
=================================

TURN_SCHEDULER -- requirements
Module: turn_scheduler

Interface
REQ-001 Parameter FPS, default 60: frame_clk ticks per second.
REQ-002 Parameter TURN_SECS, default 10: seconds allowed per aiming turn.
REQ-003 Parameter SHELL_TIMEOUT, default 240: maximum frames a shell may stay in flight.
REQ-004 Parameter SWITCH_FRAMES, default 30: dead frames between turns.
REQ-005 Port frame_clk, input, 1: the only clock; all logic is on its rising edge.
REQ-006 Port Reset, input, 1: synchronous, active-high reset.
REQ-007 Port keycode, input, 8: current keyboard code.
REQ-008 Port shoot_A / shoot_B, input, 1 each: shot-fired pulses from tank A and tank B.
REQ-009 Port shell_done, input, 1: the shell has landed or left the screen.
REQ-010 Port GG_A / GG_B, input, 1 each: tank A / tank B destroyed.
REQ-011 Port currentState, output, 1: 0 = menu/idle, 1 = match running.
REQ-012 Port control_EN_A / control_EN_B, output, 1 each: 1 = tank keyboard locked, 0 = tank may act.
REQ-013 Port turn, output, 1: 0 = tank A's turn, 1 = tank B's turn.
REQ-014 Port turn_timer, output, 5: seconds remaining in the current turn.
REQ-015 Port round_cnt, output, 8: number of completed turns.
REQ-016 Port winner, output, 2: 00 none, 01 A, 10 B, 11 draw.
REQ-017 Port state_dbg, output, 3: state encoding (IDLE=0, TURN=1, FIRE=2, SWITCH=3, GAMEOVER=4).

Function
REQ-018 The FSM SHALL have states IDLE, TURN, FIRE, SWITCH and GAMEOVER; all outputs are registered.
REQ-019 In IDLE: currentState=0, both EN=1; keycode==8'h28 (Enter) moves to TURN with turn=0, turn_timer=TURN_SECS, frame_cnt=0, round_cnt=0, winner=00.
REQ-020 In TURN: EN of the active tank =0, other EN=1, currentState=1.
REQ-021 TURN timing: frame_cnt counts 0..FPS-1; at FPS-1 it wraps to 0 and turn_timer decrements.
REQ-022 Turn expiry: a decrement from 1 to 0 moves to SWITCH with turn_timer=0, so a turn lasts exactly TURN_SECS*FPS frames.
REQ-023 A shoot pulse from the active tank in TURN moves to FIRE next edge and clears frame_cnt.
REQ-024 Shoot pulses from the inactive tank, or in any state other than TURN, SHALL be ignored.
REQ-025 If shoot and timer expiry coincide, shoot wins and the state goes to FIRE.
REQ-026 In FIRE: both EN=1; frame_cnt counts up; shell_done, or frame_cnt reaching SHELL_TIMEOUT-1, moves to SWITCH with frame_cnt cleared.
REQ-027 In SWITCH: both EN=1; after SWITCH_FRAMES frames, turn toggles, turn_timer=TURN_SECS, frame_cnt=0, round_cnt increments (saturating at 255), and the state returns to TURN.
REQ-028 From TURN, FIRE or SWITCH, GG_A or GG_B moves to GAMEOVER next edge, overriding every other transition.
REQ-029 winner SHALL be 10 if only GG_A, 01 if only GG_B, 11 if both in the same cycle.
REQ-030 In GAMEOVER: currentState=1, both EN=1, winner held; keycode==8'h29 (Esc) moves to IDLE with winner cleared.
REQ-031 GG inputs SHALL be ignored in IDLE and GAMEOVER.
REQ-032 Counter widths: frame_cnt is 9 bits and SHALL cover max(FPS, SHELL_TIMEOUT, SWITCH_FRAMES); turn_timer never wraps below 0.

Reset
REQ-033 When Reset is high at a frame_clk edge, the block SHALL go to IDLE with currentState=0, control_EN_A=1, control_EN_B=1, turn=0, turn_timer=0, round_cnt=0, winner=00, frame_cnt=0.
REQ-034 Reset SHALL take priority over every input in every state, including mid-FIRE and mid-SWITCH.

Verification (bench parameters: FPS=4, TURN_SECS=2, SHELL_TIMEOUT=6, SWITCH_FRAMES=3)
REQ-035 Expiry: Reset, then Enter; no shoot for 8 frames -> SWITCH with turn_timer=0; after 3 more frames -> TURN with turn=1, control_EN_B=0, control_EN_A=1, round_cnt=1.
REQ-036 Shot and landing: in turn A, shoot_B pulse -> no change; shoot_A pulse -> FIRE, both EN=1; shell_done 2 frames later -> SWITCH; after 3 frames -> turn=1.
REQ-037 Shell timeout: shoot_A, never assert shell_done -> SWITCH exactly 6 frames after entering FIRE.
REQ-038 Game over: GG_B during FIRE -> GAMEOVER, winner=01, then Esc -> IDLE, winner=00; separately, GG_A and GG_B in the same cycle -> winner=11.
REQ-039 Edge and reset cases: shoot_A on the same edge as expiry -> FIRE; Reset asserted in SWITCH -> IDLE with all REQ-033 values on the next edge.

Source files
------------

// File: rtl/turn_scheduler.sv
// Turn scheduler for a two-tank artillery match.
// Tracks whose turn it is, per-turn countdown, shell flight and game over.
module turn_scheduler #(
    parameter int FPS           = 60,
    parameter int TURN_SECS     = 10,
    parameter int SHELL_TIMEOUT = 240,
    parameter int SWITCH_FRAMES = 30
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic [7:0] keycode,
    input  logic       shoot_A,
    input  logic       shoot_B,
    input  logic       shell_done,
    input  logic       GG_A,
    input  logic       GG_B,
    output logic       currentState,
    output logic       control_EN_A,
    output logic       control_EN_B,
    output logic       turn,
    output logic [4:0] turn_timer,
    output logic [7:0] round_cnt,
    output logic [1:0] winner,
    output logic [2:0] state_dbg
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_TURN     = 3'd1;
    localparam logic [2:0] S_FIRE     = 3'd2;
    localparam logic [2:0] S_SWITCH   = 3'd3;
    localparam logic [2:0] S_GAMEOVER = 3'd4;

    localparam logic [7:0] KEY_ENTER = 8'h28;
    localparam logic [7:0] KEY_ESC   = 8'h29;

    localparam logic [8:0] FPS_LAST   = 9'(FPS - 1);
    localparam logic [8:0] SHELL_LAST = 9'(SHELL_TIMEOUT - 1);
    localparam logic [8:0] SW_LAST    = 9'(SWITCH_FRAMES - 1);
    localparam logic [4:0] TURN_INIT  = 5'(TURN_SECS);

    logic [2:0] state_q, state_d;
    logic [8:0] frame_cnt_q, frame_cnt_d;
    logic       turn_q, turn_d;
    logic [4:0] timer_q, timer_d;
    logic [7:0] round_q, round_d;
    logic [1:0] winner_q, winner_d;
    logic       cs_q, cs_d;
    logic       en_a_q, en_a_d;
    logic       en_b_q, en_b_d;

    logic gg;
    logic shot;

    assign gg   = GG_A | GG_B;
    assign shot = turn_q ? shoot_B : shoot_A;

    // Next-state, counter and registered-output computation.
    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        turn_d      = turn_q;
        timer_d     = timer_q;
        round_d     = round_q;
        winner_d    = winner_q;

        case (state_q)
            S_IDLE: begin
                if (keycode == KEY_ENTER) begin
                    state_d     = S_TURN;
                    turn_d      = 1'b0;
                    timer_d     = TURN_INIT;
                    frame_cnt_d = '0;
                    round_d     = '0;
                    winner_d    = 2'b00;
                end
            end
            S_TURN: begin
                if (gg) begin
                    state_d     = S_GAMEOVER;
                    winner_d    = {GG_A, GG_B};
                    frame_cnt_d = '0;
                end else if (shot) begin
                    state_d     = S_FIRE;
                    frame_cnt_d = '0;
                end else if (frame_cnt_q == FPS_LAST) begin
                    frame_cnt_d = '0;
                    if (timer_q <= 5'd1) begin
                        timer_d = '0;
                        state_d = S_SWITCH;
                    end else begin
                        timer_d = timer_q - 5'd1;
                    end
                end else begin
                    frame_cnt_d = frame_cnt_q + 9'd1;
                end
            end
            S_FIRE: begin
                if (gg) begin
                    state_d     = S_GAMEOVER;
                    winner_d    = {GG_A, GG_B};
                    frame_cnt_d = '0;
                end else if (shell_done || frame_cnt_q == SHELL_LAST) begin
                    state_d     = S_SWITCH;
                    frame_cnt_d = '0;
                end else begin
                    frame_cnt_d = frame_cnt_q + 9'd1;
                end
            end
            S_SWITCH: begin
                if (gg) begin
                    state_d     = S_GAMEOVER;
                    winner_d    = {GG_A, GG_B};
                    frame_cnt_d = '0;
                end else if (frame_cnt_q == SW_LAST) begin
                    state_d     = S_TURN;
                    turn_d      = ~turn_q;
                    timer_d     = TURN_INIT;
                    frame_cnt_d = '0;
                    if (round_q != 8'hFF) begin
                        round_d = round_q + 8'd1;
                    end
                end else begin
                    frame_cnt_d = frame_cnt_q + 9'd1;
                end
            end
            S_GAMEOVER: begin
                if (keycode == KEY_ESC) begin
                    state_d  = S_IDLE;
                    winner_d = 2'b00;
                end
            end
            default: begin
                state_d     = S_IDLE;
                frame_cnt_d = '0;
            end
        endcase

        cs_d   = (state_d != S_IDLE);
        en_a_d = !(state_d == S_TURN && !turn_d);
        en_b_d = !(state_d == S_TURN && turn_d);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            state_q     <= S_IDLE;
            frame_cnt_q <= '0;
            turn_q      <= 1'b0;
            timer_q     <= '0;
            round_q     <= '0;
            winner_q    <= 2'b00;
            cs_q        <= 1'b0;
            en_a_q      <= 1'b1;
            en_b_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
            turn_q      <= turn_d;
            timer_q     <= timer_d;
            round_q     <= round_d;
            winner_q    <= winner_d;
            cs_q        <= cs_d;
            en_a_q      <= en_a_d;
            en_b_q      <= en_b_d;
        end
    end

    assign currentState = cs_q;
    assign control_EN_A = en_a_q;
    assign control_EN_B = en_b_q;
    assign turn         = turn_q;
    assign turn_timer   = timer_q;
    assign round_cnt    = round_q;
    assign winner       = winner_q;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_turn_scheduler.sv
// Bench for turn_scheduler: directed scenarios then random traffic,
// every cycle checked against a frame-counting reference model.
module tb_turn_scheduler;

    localparam int FPS = 4;
    localparam int TS  = 2;
    localparam int SHT = 6;
    localparam int SW  = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] key = 8'h00;
    logic       sa = 1'b0, sb = 1'b0, sd = 1'b0, ga = 1'b0, gb = 1'b0;
    logic       cs, en_a, en_b, turn;
    logic [4:0] timer;
    logic [7:0] rnd;
    logic [1:0] win;
    logic [2:0] st;

    int n_vec = 0;
    int n_err = 0;

    // reference model: phase + frames elapsed within the phase
    int m_mode = 0;
    int m_el = 0;
    int m_turn = 0;
    int m_timer = 0;
    int m_round = 0;
    int m_win = 0;

    always #5 clk = ~clk;

    turn_scheduler #(
        .FPS(FPS), .TURN_SECS(TS), .SHELL_TIMEOUT(SHT), .SWITCH_FRAMES(SW)
    ) dut (
        .frame_clk(clk), .Reset(rst), .keycode(key),
        .shoot_A(sa), .shoot_B(sb), .shell_done(sd),
        .GG_A(ga), .GG_B(gb),
        .currentState(cs), .control_EN_A(en_a), .control_EN_B(en_b),
        .turn(turn), .turn_timer(timer), .round_cnt(rnd),
        .winner(win), .state_dbg(st)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        if (rst) begin
            m_mode = 0; m_el = 0; m_turn = 0;
            m_timer = 0; m_round = 0; m_win = 0;
        end else if (m_mode == 0) begin
            if (key == 8'h28) begin
                m_mode = 1; m_turn = 0; m_timer = TS;
                m_el = 0; m_round = 0; m_win = 0;
            end
        end else if (m_mode == 4) begin
            if (key == 8'h29) begin
                m_mode = 0; m_win = 0;
            end
        end else if (ga || gb) begin
            m_mode = 4;
            m_win = (ga ? 2 : 0) + (gb ? 1 : 0);
        end else if (m_mode == 1) begin
            if ((m_turn == 0 && sa) || (m_turn == 1 && sb)) begin
                m_mode = 2; m_el = 0;
            end else begin
                m_el++;
                if (m_el == TS * FPS) begin
                    m_mode = 3; m_el = 0; m_timer = 0;
                end else begin
                    m_timer = TS - m_el / FPS;
                end
            end
        end else if (m_mode == 2) begin
            if (sd || m_el == SHT - 1) begin
                m_mode = 3; m_el = 0;
            end else begin
                m_el++;
            end
        end else begin
            if (m_el == SW - 1) begin
                m_mode = 1; m_el = 0; m_turn = 1 - m_turn;
                m_timer = TS;
                if (m_round < 255) m_round++;
            end else begin
                m_el++;
            end
        end
    endtask

    task automatic cyc(input logic r, input logic [7:0] k,
                       input logic a, input logic b, input logic d,
                       input logic gA, input logic gB);
        rst = r; key = k; sa = a; sb = b; sd = d; ga = gA; gb = gB;
        @(posedge clk);
        model_step();
        #1;
        chk("state", int'(st), m_mode);
        chk("currentState", int'(cs), (m_mode != 0) ? 1 : 0);
        chk("en_a", int'(en_a), (m_mode == 1 && m_turn == 0) ? 0 : 1);
        chk("en_b", int'(en_b), (m_mode == 1 && m_turn == 1) ? 0 : 1);
        chk("turn", int'(turn), m_turn);
        chk("turn_timer", int'(timer), m_timer);
        chk("round_cnt", int'(rnd), m_round);
        chk("winner", int'(win), m_win);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 8'h00, 0, 0, 0, 0, 0);
    endtask

    task automatic start();
        cyc(1, 8'h00, 0, 0, 0, 0, 0);
        cyc(0, 8'h28, 0, 0, 0, 0, 0);
    endtask

    initial begin
        // expiry
        start();
        chk("enter_state", int'(st), 1);
        chk("enter_timer", int'(timer), TS);
        idle(7);
        chk("pre_expiry", int'(st), 1);
        idle(1);
        chk("expiry_state", int'(st), 3);
        chk("expiry_timer", int'(timer), 0);
        idle(3);
        chk("b_turn_state", int'(st), 1);
        chk("b_turn", int'(turn), 1);
        chk("b_en_b", int'(en_b), 0);
        chk("b_en_a", int'(en_a), 1);
        chk("b_round", int'(rnd), 1);

        // shot and landing
        start();
        cyc(0, 8'h00, 0, 1, 0, 0, 0);
        chk("ignore_sb", int'(st), 1);
        cyc(0, 8'h00, 1, 0, 0, 0, 0);
        chk("fire_state", int'(st), 2);
        chk("fire_en", int'({en_a, en_b}), 3);
        idle(1);
        cyc(0, 8'h00, 0, 0, 1, 0, 0);
        chk("land_state", int'(st), 3);
        idle(3);
        chk("land_turn", int'(turn), 1);

        // shell timeout
        start();
        cyc(0, 8'h00, 1, 0, 0, 0, 0);
        idle(5);
        chk("timeout_pre", int'(st), 2);
        idle(1);
        chk("timeout_state", int'(st), 3);

        // game over
        start();
        cyc(0, 8'h00, 1, 0, 0, 0, 0);
        cyc(0, 8'h00, 0, 0, 0, 0, 1);
        chk("go_state", int'(st), 4);
        chk("go_winner", int'(win), 1);
        cyc(0, 8'h00, 0, 0, 0, 1, 0);
        chk("go_hold", int'(win), 1);
        cyc(0, 8'h29, 0, 0, 0, 0, 0);
        chk("esc_state", int'(st), 0);
        chk("esc_winner", int'(win), 0);
        start();
        cyc(0, 8'h00, 0, 0, 0, 1, 1);
        chk("draw", int'(win), 3);

        // shoot on expiry edge, then reset mid-switch
        start();
        idle(7);
        cyc(0, 8'h00, 1, 0, 0, 0, 0);
        chk("shoot_wins", int'(st), 2);
        cyc(0, 8'h00, 0, 0, 1, 0, 0);
        idle(1);
        chk("pre_rst", int'(st), 3);
        cyc(1, 8'h00, 0, 0, 0, 0, 0);
        chk("rst_state", int'(st), 0);
        chk("rst_en", int'({cs, en_a, en_b}), 3);
        chk("rst_vals", int'({turn, timer, rnd, win}), 0);

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            int r;
            logic [7:0] k;
            r = int'($urandom_range(0, 15));
            k = (r == 0) ? 8'h28 : (r == 1) ? 8'h29 : 8'($urandom);
            cyc($urandom_range(0, 299) == 0, k,
                $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                $urandom_range(0, 9) == 0,
                $urandom_range(0, 79) == 0, $urandom_range(0, 79) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
